// File: rtl/gray_decoder.sv
// Gray-code stream receiver: decodes to binary, classifies each step as
// hold/up/down/illegal, and tracks lock after LOCK_CNT consecutive legal steps.
module gray_decoder #(
   parameter int WIDTH    = 3,
   parameter int LOCK_CNT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             g_valid,
   input  logic [WIDTH-1:0] g_in,
   output logic [WIDTH-1:0] bin_out,
   output logic             bin_valid,
   output logic             dir,
   output logic             wrap,
   output logic             err,
   output logic             locked,
   output logic [7:0]       err_cnt
);

   localparam logic [1:0] EMPTY   = 2'd0;
   localparam logic [1:0] ACQUIRE = 2'd1;
   localparam logic [1:0] LOCKED  = 2'd2;

   localparam int CW = $clog2(LOCK_CNT + 1);

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] ref_q;
   logic [WIDTH-1:0] b_new;
   logic [WIDTH-1:0] delta;
   logic             is_hold;
   logic             is_up;
   logic             is_down;
   logic             is_illegal;

   // Binary bit i is the XOR of all gray bits at or above i.
   always_comb begin
      b_new = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         b_new[i] = ^(g_in >> i);
      end
   end

   always_comb begin
      delta      = b_new - ref_q;
      is_hold    = (delta == '0);
      is_up      = (delta == WIDTH'(1));
      is_down    = (delta == '1);
      is_illegal = !(is_hold || is_up || is_down);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= EMPTY;
         cnt       <= '0;
         ref_q     <= '0;
         bin_out   <= '0;
         bin_valid <= 1'b0;
         dir       <= 1'b0;
         wrap      <= 1'b0;
         err       <= 1'b0;
         locked    <= 1'b0;
         err_cnt   <= '0;
      end else begin
         bin_valid <= 1'b0;
         wrap      <= 1'b0;
         err       <= 1'b0;
         if (g_valid) begin
            bin_out   <= b_new;
            ref_q     <= b_new;
            bin_valid <= 1'b1;
            case (state)
               ACQUIRE, LOCKED: begin
                  if (is_up || is_down) begin
                     dir  <= is_up;
                     // up from all-ones lands on 0; down from 0 lands on all-ones
                     wrap <= (is_up && ref_q == '1) || (is_down && ref_q == '0);
                  end
                  if (is_illegal) begin
                     err    <= 1'b1;
                     cnt    <= '0;
                     locked <= 1'b0;
                     state  <= ACQUIRE;
                     if (err_cnt != 8'hFF) begin
                        err_cnt <= err_cnt + 8'd1;
                     end
                  end else if (state == ACQUIRE && (is_up || is_down)) begin
                     cnt <= cnt + CW'(1);
                     if (cnt == CW'(LOCK_CNT - 1)) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                     end
                  end
               end
               default: begin
                  state <= ACQUIRE;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_gray_decoder.sv
// Directed-vector bench for gray_decoder (WIDTH=3, LOCK_CNT=2).
module tb_gray_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       g_valid;
   logic [2:0] g_in;
   logic [2:0] bin_out;
   logic       bin_valid;
   logic       dir;
   logic       wrap;
   logic       err;
   logic       locked;
   logic [7:0] err_cnt;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   gray_decoder #(.WIDTH(3), .LOCK_CNT(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .g_valid   (g_valid),
      .g_in      (g_in),
      .bin_out   (bin_out),
      .bin_valid (bin_valid),
      .dir       (dir),
      .wrap      (wrap),
      .err       (err),
      .locked    (locked),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic send(input logic [2:0] g);
      @(negedge clk);
      g_valid = 1'b1;
      g_in    = g;
      @(posedge clk);
      #1;
      g_valid = 1'b0;
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         check("idle_bin_valid", bin_valid, 0);
         check("idle_err", err, 0);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst     = 1'b1;
      g_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   logic [2:0] t1_gray [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
   logic [2:0] t1_bin  [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
   logic       t1_lock [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
   logic       t1_dir  [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
   logic       t1_wrap [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      rst     = 1'b1;
      g_valid = 1'b0;
      g_in    = 3'b000;
      #2;
      check("rst_bin_out", bin_out, 0);
      check("rst_bin_valid", bin_valid, 0);
      check("rst_locked", locked, 0);
      check("rst_err_cnt", err_cnt, 0);
      @(negedge clk);
      rst = 1'b0;

      // 1: full upward sweep with wrap 7->0
      for (int i = 0; i < 9; i++) begin
         send(t1_gray[i]);
         check("t1_bin_out", bin_out, t1_bin[i]);
         check("t1_bin_valid", bin_valid, 1);
         check("t1_locked", locked, t1_lock[i]);
         check("t1_dir", dir, t1_dir[i]);
         check("t1_wrap", wrap, t1_wrap[i]);
         check("t1_err", err, 0);
      end
      idle(1);
      check("t1_wrap_clear", wrap, 0);

      // 2: down-wrap 0->7 while locked
      send(3'b100);
      check("t2_bin_out", bin_out, 7);
      check("t2_dir", dir, 0);
      check("t2_wrap", wrap, 1);
      check("t2_locked", locked, 1);
      check("t2_err", err, 0);

      // 3: walk up to bin 2, then illegal jump to bin 4, then relock
      send(3'b000);
      check("t3_wrap_up", wrap, 1);
      check("t3_dir_up", dir, 1);
      send(3'b001);
      send(3'b011);
      check("t3_bin2", bin_out, 2);
      check("t3_locked_pre", locked, 1);
      send(3'b110);
      check("t3_err", err, 1);
      check("t3_err_cnt", err_cnt, 1);
      check("t3_unlocked", locked, 0);
      check("t3_bin_out", bin_out, 4);
      check("t3_bin_valid", bin_valid, 1);
      send(3'b111);
      check("t3_err_clear", err, 0);
      check("t3_locked_mid", locked, 0);
      send(3'b101);
      check("t3_relocked", locked, 1);
      check("t3_bin6", bin_out, 6);

      // 4: holds with gaps give no lock progress
      do_reset();
      check("t4_rst_err_cnt", err_cnt, 0);
      send(3'b001);
      send(3'b011);
      check("t4_dir", dir, 1);
      check("t4_locked_start", locked, 0);
      for (int i = 0; i < 3; i++) begin
         idle(2);
         send(3'b011);
         check("t4_bin_valid", bin_valid, 1);
         check("t4_bin_out", bin_out, 2);
         check("t4_err", err, 0);
         check("t4_locked", locked, 0);
         check("t4_dir_hold", dir, 1);
      end
      send(3'b010);
      check("t4_lock_after_hold", locked, 1);

      // 5: repeated illegal jumps saturate err_cnt
      do_reset();
      for (int k = 0; k < 300; k++) begin
         send((k % 2) ? 3'b110 : 3'b000);
         if (k == 0) check("t5_first_err", err, 0);
         else        check("t5_err", err, 1);
         if (k == 100) check("t5_err_cnt_100", err_cnt, 100);
         if (k == 255) check("t5_err_cnt_255", err_cnt, 255);
      end
      check("t5_err_cnt_sat", err_cnt, 255);

      // 6: asynchronous reset mid-operation
      send(3'b111);
      send(3'b101);
      check("t6_locked", locked, 1);
      check("t6_err_cnt_hold", err_cnt, 255);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("t6_async_bin_out", bin_out, 0);
      check("t6_async_locked", locked, 0);
      check("t6_async_dir", dir, 0);
      check("t6_async_err_cnt", err_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      send(3'b010);
      check("t6_bin_out", bin_out, 3);
      check("t6_bin_valid", bin_valid, 1);
      check("t6_err", err, 0);
      check("t6_locked_after", locked, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
